// File: rtl/moxie_rst_pkg.sv
// Shared encodings for the moxiesoc reset controller: reset causes, FSM states
// and a saturating counter helper.
package moxie_rst_pkg;

  typedef enum logic [1:0] {
    RST_CAUSE_POR = 2'b00,
    RST_CAUSE_BTN = 2'b01,
    RST_CAUSE_SW  = 2'b10,
    RST_CAUSE_WDT = 2'b11
  } rst_cause_e;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_e;

  localparam int RST_COUNT_W = 8;

  function automatic logic [RST_COUNT_W-1:0] sat_inc8(input logic [RST_COUNT_W-1:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/moxie_rst_ctrl_sync.sv
// Multi-flop synchronizer whose whole chain is asynchronously set to 1.
module moxie_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_set,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_set) begin
    if (i_set) begin
      r_chain <= '1;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/moxie_rst_ctrl.sv
// Reset controller for moxiesoc: merges board, button and software resets into a
// stretched reset with cause/count reporting. Optional watchdog: MOXIE_RST_WDT_EN.
module moxie_rst_ctrl
  import moxie_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int WDT_CYCLES      = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_rst_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_kick_i,
  output logic       rst_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  logic        w_rst_sync;
  logic        w_btn_sync;
  logic        w_btn_fire;
  logic        w_wdt_fire;
  logic        w_req;
  rst_cause_e  w_next_cause;

  rst_state_e        r_state;
  logic              r_rst;
  rst_cause_e        r_cause;
  logic [7:0]        r_count;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DEB_W-1:0]  r_deb_cnt;

  moxie_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .i_clk (clk_i),
    .i_set (rst_i),
    .i_d   (1'b0),
    .o_q   (w_rst_sync)
  );

  moxie_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .i_clk (clk_i),
    .i_set (rst_i),
    .i_d   (btn_rst_i),
    .o_q   (w_btn_sync)
  );

  assign w_btn_fire = w_btn_sync && (r_deb_cnt == DEB_LAST);

`ifdef MOXIE_RST_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
  logic [WDT_W-1:0] r_wdt_cnt;
  // A kick wins over an expiry landing on the same cycle.
  assign w_wdt_fire = !wdt_kick_i && (r_wdt_cnt == WDT_LAST);
`else
  logic w_unused_wdt_kick;
  assign w_unused_wdt_kick = wdt_kick_i;
  assign w_wdt_fire        = 1'b0;
`endif

  // Warm-reset request arbitration: BTN > WDT > SW.
  always_comb begin
    w_req        = 1'b0;
    w_next_cause = RST_CAUSE_SW;
    if (w_btn_fire) begin
      w_req        = 1'b1;
      w_next_cause = RST_CAUSE_BTN;
    end else if (w_wdt_fire) begin
      w_req        = 1'b1;
      w_next_cause = RST_CAUSE_WDT;
    end else if (sw_rst_req_i) begin
      w_req        = 1'b1;
      w_next_cause = RST_CAUSE_SW;
    end else begin
      w_req        = 1'b0;
      w_next_cause = RST_CAUSE_SW;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_HOLD;
      r_rst      <= 1'b1;
      r_cause    <= RST_CAUSE_POR;
      r_count    <= 8'd0;
      r_hold_cnt <= '0;
      r_deb_cnt  <= '0;
`ifdef MOXIE_RST_WDT_EN
      r_wdt_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        ST_HOLD: begin
          // A button reset is held until the button itself is released.
          if (w_rst_sync || (w_btn_sync && (r_cause == RST_CAUSE_BTN))) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_rst      <= 1'b0;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
        end
        ST_RUN: begin
          if (w_req) begin
            r_state    <= ST_HOLD;
            r_rst      <= 1'b1;
            r_cause    <= w_next_cause;
            r_count    <= sat_inc8(r_count);
            r_hold_cnt <= '0;
            r_deb_cnt  <= '0;
`ifdef MOXIE_RST_WDT_EN
            r_wdt_cnt  <= '0;
`endif
          end else begin
            r_deb_cnt <= w_btn_sync ? (r_deb_cnt + DEB_ONE) : '0;
`ifdef MOXIE_RST_WDT_EN
            r_wdt_cnt <= wdt_kick_i ? '0 : (r_wdt_cnt + WDT_ONE);
`endif
          end
        end
        default: begin
          r_state <= ST_HOLD;
          r_rst   <= 1'b1;
        end
      endcase
    end
  end

  assign rst_o       = r_rst;
  assign rst_cause_o = r_cause;
  assign rst_count_o = r_count;

endmodule

// File: tb/tb_moxie_rst_ctrl.sv
// Directed scoreboard bench for moxie_rst_ctrl; the watchdog section follows
// MOXIE_RST_WDT_EN.
module tb_moxie_rst_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       btn_rst_i;
  logic       sw_rst_req_i;
  logic       wdt_kick_i;
  logic       rst_o;
  logic [1:0] rst_cause_o;
  logic [7:0] rst_count_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic [1:0] cause;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];

  moxie_rst_ctrl #(
    .SYNC_STAGES     (2),
    .HOLD_CYCLES     (16),
    .DEBOUNCE_CYCLES (1024),
    .WDT_CYCLES      (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .btn_rst_i    (btn_rst_i),
    .sw_rst_req_i (sw_rst_req_i),
    .wdt_kick_i   (wdt_kick_i),
    .rst_o        (rst_o),
    .rst_cause_o  (rst_cause_o),
    .rst_count_o  (rst_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic r, input logic [1:0] c, input logic [7:0] n);
    exp_t e;
    e.tag = tag; e.rst = r; e.cause = c; e.count = n;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end else begin
      e = sb.pop_front();
      checks++;
      assert ({rst_o, rst_cause_o, rst_count_o} === {e.rst, e.cause, e.count}) else begin
        errors++;
        $error("FAIL %s: observed rst=%0b cause=%02b count=%0d, expected rst=%0b cause=%02b count=%0d",
               e.tag, rst_o, rst_cause_o, rst_count_o, e.rst, e.cause, e.count);
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    btn_rst_i    = 1'b0;
    sw_rst_req_i = 1'b0;
    wdt_kick_i   = 1'b1;

    // Power-on: reset held, release, stretch to edge 18.
    step(5);
    expect_out("por_in_reset", 1'b1, 2'b00, 8'd0); check_out();
    rst_i = 1'b0;
    expect_out("por_edge17", 1'b1, 2'b00, 8'd0); step(17); check_out();
    expect_out("por_edge18", 1'b0, 2'b00, 8'd0); step(1);  check_out();

    // Short button bounce is filtered.
    btn_rst_i = 1'b1;
    expect_out("btn_glitch_500", 1'b0, 2'b00, 8'd0); step(500); check_out();
    btn_rst_i = 1'b0;
    expect_out("btn_glitch_after", 1'b0, 2'b00, 8'd0); step(5); check_out();

    // Real press: reset at edge 1026, held while pressed, released 18 edges after.
    btn_rst_i = 1'b1;
    expect_out("btn_edge1025", 1'b0, 2'b00, 8'd0); step(1025); check_out();
    expect_out("btn_edge1026", 1'b1, 2'b01, 8'd1); step(1);    check_out();
    expect_out("btn_held",     1'b1, 2'b01, 8'd1); step(74);   check_out();
    btn_rst_i = 1'b0;
    expect_out("btn_rel_17", 1'b1, 2'b01, 8'd1); step(17); check_out();
    expect_out("btn_rel_18", 1'b0, 2'b01, 8'd1); step(1);  check_out();

    // Software reset; second pulse inside HOLD is ignored.
    sw_rst_req_i = 1'b1;
    expect_out("sw_assert", 1'b1, 2'b10, 8'd2); step(1); check_out();
    sw_rst_req_i = 1'b0;
    step(3);
    sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
    expect_out("sw_hold_last", 1'b1, 2'b10, 8'd2); step(11); check_out();
    expect_out("sw_release",   1'b0, 2'b10, 8'd2); step(1);  check_out();

    // Third warm reset, then board reset in the middle of its HOLD.
    sw_rst_req_i = 1'b1;
    expect_out("sw_count3", 1'b1, 2'b10, 8'd3); step(1); check_out();
    sw_rst_req_i = 1'b0;
    step(5);
    rst_i = 1'b1;
    #1;
    expect_out("midhold_async", 1'b1, 2'b00, 8'd0); check_out();
    step(2);
    rst_i = 1'b0;
    expect_out("midhold_edge17", 1'b1, 2'b00, 8'd0); step(17); check_out();
    expect_out("midhold_edge18", 1'b0, 2'b00, 8'd0); step(1);  check_out();

    // Debounce completion and software request on the same edge.
    btn_rst_i = 1'b1;
    step(1025);
    sw_rst_req_i = 1'b1;
    expect_out("simul_btn_wins", 1'b1, 2'b01, 8'd1); step(1); check_out();
    sw_rst_req_i = 1'b0;
    btn_rst_i    = 1'b0;
    expect_out("simul_release", 1'b0, 2'b01, 8'd1); step(18); check_out();

    // Count saturation over 300 software resets.
    for (int i = 0; i < 300; i++) begin
      sw_rst_req_i = 1'b1;
      step(1);
      sw_rst_req_i = 1'b0;
      if (i == 0) begin
        expect_out("sat_first", 1'b1, 2'b10, 8'd2); check_out();
      end
      step(15);
      if (i == 253) begin
        expect_out("sat_reach", 1'b1, 2'b10, 8'd255); check_out();
      end
      step(1);
    end
    expect_out("sat_final", 1'b0, 2'b10, 8'd255); check_out();

`ifdef MOXIE_RST_WDT_EN
    // Periodic kicks keep the watchdog quiet, then expiry after 64 unkicked cycles.
    wdt_kick_i = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wdt_kick_i = 1'b1; step(1); wdt_kick_i = 1'b0; step(59);
    end
    expect_out("wdt_kicked", 1'b0, 2'b10, 8'd255); check_out();
    wdt_kick_i = 1'b1; step(1); wdt_kick_i = 1'b0;
    expect_out("wdt_edge63", 1'b0, 2'b10, 8'd255); step(63); check_out();
    expect_out("wdt_fire",   1'b1, 2'b11, 8'd255); step(1);  check_out();
    wdt_kick_i = 1'b1;
    expect_out("wdt_release", 1'b0, 2'b11, 8'd255); step(16); check_out();
`else
    // Without the watchdog, no kicks never cause a reset.
    wdt_kick_i = 1'b0;
    expect_out("wdt_absent", 1'b0, 2'b10, 8'd255); step(200); check_out();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
